// File: rtl/sw_seq_lock.sv
// sw_seq_lock: switch-sequence lock. Detects single-switch press events,
// matches them against a programmable code, opens on a full correct entry,
// counts consecutive failures and enters a timed lockout after MAX_FAIL.
module sw_seq_lock #(
    parameter int NUM_SW      = 4,
    parameter int SEQ_LEN     = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 16,
    parameter int IDXW        = $clog2(NUM_SW)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SW-1:0]             sw,
    input  logic [SEQ_LEN*IDXW-1:0]       code,
    input  logic                          clear,
    output logic [2:0]                    state,
    output logic [$clog2(SEQ_LEN+1)-1:0]  progress,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
    output logic                          unlocked,
    output logic                          alarm
);

    localparam int PW = $clog2(SEQ_LEN + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    // Timer counts LOCKOUT_CYC-1 down to 0; keep at least one bit.
    localparam int TW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_FAIL    = 3'd3;
    localparam logic [2:0] S_LOCKOUT = 3'd4;

    logic [2:0]        state_q,    state_d;
    logic [PW-1:0]     progress_q, progress_d;
    logic [FW-1:0]     fail_cnt_q, fail_cnt_d;
    logic [NUM_SW-1:0] sw_prev_q;
    logic [TW-1:0]     timer_q,    timer_d;

    logic              press_ev;
    logic              good_press;
    logic              match;
    logic [IDXW-1:0]   press_sym;
    logic [IDXW-1:0]   exp_sym;
    logic [PW-1:0]     progress_inc;
    logic [FW-1:0]     fail_cnt_inc;

    // Index of the (single) set bit of a switch vector.
    function automatic logic [IDXW-1:0] sw_index(input logic [NUM_SW-1:0] v);
        sw_index = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            if (v[i]) sw_index = IDXW'(i);
        end
    endfunction

    // Code symbol at position p; positions past the code read as zero.
    function automatic logic [IDXW-1:0] code_sym(input logic [SEQ_LEN*IDXW-1:0] c,
                                                 input logic [PW-1:0] p);
        code_sym = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (p == PW'(i)) code_sym = c[i*IDXW +: IDXW];
        end
    endfunction

    // Press detection: rising from all-released, then classify and compare live.
    always_comb begin
        press_ev     = (sw_prev_q == '0) && (sw != '0);
        good_press   = $onehot(sw);
        press_sym    = sw_index(sw);
        exp_sym      = code_sym(code, progress_q);
        match        = press_ev && good_press && (press_sym == exp_sym);
        progress_inc = progress_q + PW'(1);
        fail_cnt_inc = fail_cnt_q + FW'(1);
    end

    // State, counters, lockout timer and previous switch sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            progress_q <= '0;
            fail_cnt_q <= '0;
            sw_prev_q  <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            progress_q <= progress_d;
            fail_cnt_q <= fail_cnt_d;
            sw_prev_q  <= sw;
            timer_q    <= timer_d;
        end
    end

    // Next-state logic; entering FAIL clears progress and bumps the fail count.
    always_comb begin
        state_d    = state_q;
        progress_d = progress_q;
        fail_cnt_d = fail_cnt_q;
        timer_d    = timer_q;
        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (clear) begin
                    state_d    = S_IDLE;
                    progress_d = '0;
                end else if (match) begin
                    if (progress_inc == PW'(SEQ_LEN)) begin
                        state_d    = S_OPEN;
                        progress_d = '0;
                        fail_cnt_d = '0;
                    end else begin
                        state_d    = S_ENTRY;
                        progress_d = progress_inc;
                    end
                end else if (press_ev) begin
                    state_d    = S_FAIL;
                    progress_d = '0;
                    fail_cnt_d = fail_cnt_inc;
                end
            end
            S_OPEN: begin
                if (clear || press_ev) begin
                    state_d    = S_IDLE;
                    progress_d = '0;
                end
            end
            S_FAIL: begin
                if (fail_cnt_q == FW'(MAX_FAIL)) begin
                    state_d = S_LOCKOUT;
                    timer_d = TW'(LOCKOUT_CYC - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d    = S_IDLE;
                    fail_cnt_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d    = S_IDLE;
                progress_d = '0;
            end
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        state    = state_q;
        progress = progress_q;
        fail_cnt = fail_cnt_q;
        unlocked = (state_q == S_OPEN);
        alarm    = (state_q == S_LOCKOUT);
    end

endmodule

// File: tb/tb_sw_seq_lock.sv
// Directed bench for sw_seq_lock at default parameters, code = {3,2,1,0}.
module tb_sw_seq_lock;

    logic       clk;
    logic       reset;
    logic [3:0] sw;
    logic [7:0] code;
    logic       clear;
    logic [2:0] state;
    logic [2:0] progress;
    logic [1:0] fail_cnt;
    logic       unlocked;
    logic       alarm;

    int n_vec = 0;
    int n_err = 0;

    sw_seq_lock dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .code     (code),
        .clear    (clear),
        .state    (state),
        .progress (progress),
        .fail_cnt (fail_cnt),
        .unlocked (unlocked),
        .alarm    (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press v (held 2 cycles, released 2 cycles); check state/progress after the press edge.
    task automatic press_chk(input string tag, input logic [3:0] v,
                             input logic [2:0] exp_st, input logic [2:0] exp_pr);
        sw = v;
        tick();
        chk({tag, ".state"}, 32'(state), 32'(exp_st));
        chk({tag, ".prog"},  32'(progress), 32'(exp_pr));
        tick();
        sw = 4'b0000;
        tick(2);
    endtask

    // Wrong press that lands in FAIL; check fail count and one-cycle FAIL.
    task automatic wrong_chk(input string tag, input logic [3:0] v,
                             input logic [1:0] exp_fc, input logic [2:0] exp_after);
        sw = v;
        tick();
        chk({tag, ".fail_st"}, 32'(state), 32'd3);
        chk({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(exp_fc));
        chk({tag, ".fail_prog"}, 32'(progress), 32'd0);
        tick();
        chk({tag, ".after_st"}, 32'(state), 32'(exp_after));
        sw = 4'b0000;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        sw    = 4'b0000;
        clear = 1'b0;
        code  = {2'd3, 2'd2, 2'd1, 2'd0};
        #12;
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.prog", 32'(progress), 32'd0);
        chk("rst.fail", 32'(fail_cnt), 32'd0);
        chk("rst.unl", 32'(unlocked), 32'd0);
        chk("rst.alarm", 32'(alarm), 32'd0);
        reset = 1'b1;
        tick();

        // 1: correct entry opens, next press relocks
        press_chk("t1.p0", 4'b0001, 3'd1, 3'd1);
        press_chk("t1.p1", 4'b0010, 3'd1, 3'd2);
        press_chk("t1.p2", 4'b0100, 3'd1, 3'd3);
        sw = 4'b1000;
        tick();
        chk("t1.open.state", 32'(state), 32'd2);
        chk("t1.open.unl", 32'(unlocked), 32'd1);
        chk("t1.open.fail", 32'(fail_cnt), 32'd0);
        chk("t1.open.prog", 32'(progress), 32'd0);
        tick();
        chk("t1.open.held", 32'(state), 32'd2);
        sw = 4'b0000;
        tick(2);
        sw = 4'b0001;
        tick();
        chk("t1.relock.state", 32'(state), 32'd0);
        chk("t1.relock.unl", 32'(unlocked), 32'd0);
        tick();
        sw = 4'b0000;
        tick(2);

        // 2: wrong third symbol
        press_chk("t2.p0", 4'b0001, 3'd1, 3'd1);
        press_chk("t2.p1", 4'b0010, 3'd1, 3'd2);
        wrong_chk("t2.w", 4'b1000, 2'd1, 3'd0);
        chk("t2.prog", 32'(progress), 32'd0);
        chk("t2.fail", 32'(fail_cnt), 32'd1);
        tick(2);

        // 3: three failures lead to a 16-cycle lockout that ignores inputs
        do_reset();
        wrong_chk("t3.w1", 4'b0100, 2'd1, 3'd0);
        tick(2);
        wrong_chk("t3.w2", 4'b0100, 2'd2, 3'd0);
        tick(2);
        wrong_chk("t3.w3", 4'b0100, 2'd3, 3'd4);
        chk("t3.alarm", 32'(alarm), 32'd1);
        for (int i = 2; i <= 16; i++) begin
            sw    = (i == 3 || i == 4 || i >= 12) ? 4'b0001 : 4'b0000;
            clear = (i == 8);
            tick();
            chk($sformatf("t3.lock%0d.state", i), 32'(state), 32'd4);
            chk($sformatf("t3.lock%0d.alarm", i), 32'(alarm), 32'd1);
        end
        clear = 1'b0;
        tick();
        chk("t3.exit.state", 32'(state), 32'd0);
        chk("t3.exit.fail", 32'(fail_cnt), 32'd0);
        chk("t3.exit.alarm", 32'(alarm), 32'd0);
        tick();
        chk("t3.held.state", 32'(state), 32'd0);
        chk("t3.held.prog", 32'(progress), 32'd0);
        sw = 4'b0000;
        tick(2);

        // 4: multi-bit press fails; a long hold is one event
        do_reset();
        wrong_chk("t4.bad", 4'b0011, 2'd1, 3'd0);
        tick(2);
        sw = 4'b0001;
        tick();
        chk("t4.hold1.prog", 32'(progress), 32'd1);
        tick(4);
        chk("t4.hold5.state", 32'(state), 32'd1);
        chk("t4.hold5.prog", 32'(progress), 32'd1);
        sw = 4'b0000;
        tick(2);

        // 5: clear wins over a simultaneous correct press
        press_chk("t5.p1", 4'b0010, 3'd1, 3'd2);
        sw    = 4'b0100;
        clear = 1'b1;
        tick();
        chk("t5.clr.state", 32'(state), 32'd0);
        chk("t5.clr.prog", 32'(progress), 32'd0);
        chk("t5.clr.fail", 32'(fail_cnt), 32'd1);
        clear = 1'b0;
        tick();
        sw = 4'b0000;
        tick(2);

        // 6: asynchronous reset mid-entry and mid-lockout
        do_reset();
        wrong_chk("t6.w0", 4'b1000, 2'd1, 3'd0);
        tick(2);
        press_chk("t6.p0", 4'b0001, 3'd1, 3'd1);
        press_chk("t6.p1", 4'b0010, 3'd1, 3'd2);
        press_chk("t6.p2", 4'b0100, 3'd1, 3'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("t6.ra.state", 32'(state), 32'd0);
        chk("t6.ra.prog", 32'(progress), 32'd0);
        chk("t6.ra.fail", 32'(fail_cnt), 32'd0);
        reset = 1'b1;
        tick();
        wrong_chk("t6.w1", 4'b0100, 2'd1, 3'd0);
        tick(2);
        wrong_chk("t6.w2", 4'b0100, 2'd2, 3'd0);
        tick(2);
        wrong_chk("t6.w3", 4'b0100, 2'd3, 3'd4);
        tick(3);
        #2;
        reset = 1'b0;
        #1;
        chk("t6.rb.state", 32'(state), 32'd0);
        chk("t6.rb.alarm", 32'(alarm), 32'd0);
        chk("t6.rb.fail", 32'(fail_cnt), 32'd0);
        chk("t6.rb.prog", 32'(progress), 32'd0);
        reset = 1'b1;
        tick(2);
        chk("t6.post.state", 32'(state), 32'd0);
        press_chk("t6.post.p0", 4'b0001, 3'd1, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sw_seq_lock.md
Name: sw_seq_lock

Overview:
Parametrised switch-sequence FSM. It is the successor to the fixed 4-switch / 5-state switch FSM. It detects single-switch press events on NUM_SW switches and compares them against a programmable SEQ_LEN-symbol code. It asserts unlocked on a full correct entry, counts failed attempts, and enters a timed lockout after MAX_FAIL failures. It sits between the board switch inputs and the LED/7-seg status logic.

Parameters:
NUM_SW, 4, number of switch inputs (>=2)
SEQ_LEN, 4, symbols in the code (>=1)
MAX_FAIL, 3, consecutive failed attempts that trigger lockout (>=1)
LOCKOUT_CYC, 16, clock cycles spent in LOCKOUT (>=1)
IDXW, $clog2(NUM_SW), width of one code symbol (derived)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
sw  in  NUM_SW  raw switch levels, synchronous to clk
code  in  SEQ_LEN*IDXW  expected switch index per position; symbol i at bits [i*IDXW +: IDXW]
clear  in  1  synchronous abort of the current entry
state  out  3  current state encoding
progress  out  $clog2(SEQ_LEN+1)  correct symbols entered so far
fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures
unlocked  out  1  high while state==OPEN
alarm  out  1  high while state==LOCKOUT

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, progress=0, fail_cnt=0, sw_prev=0, lock timer=0, unlocked=0, alarm=0.
- State encodings: IDLE=0, ENTRY=1, OPEN=2, FAIL=3, LOCKOUT=4. Values 5-7 are illegal and go to IDLE on the next clock.
- sw_prev is a register holding sw from the previous cycle.
- A press event occurs on a clock edge where sw_prev==0 and sw!=0.
- A good press has exactly one bit set; its symbol is the index of that bit.
- A press with two or more bits set is a bad press.
- A held switch produces exactly one event. A new event requires sw to return to all-zero first.
- Match test: the press is good and its symbol equals code symbol [progress]. code is compared live; a change to code mid-entry affects later compares only.
- Outputs unlocked and alarm are decodes of the registered state. The state change takes effect on the same edge that samples the press (0-cycle input-to-state latency; outputs valid after the edge).
- IDLE:
  - match -> ENTRY, progress=1; if SEQ_LEN==1 -> OPEN instead.
  - non-match press -> FAIL.
- ENTRY:
  - match -> progress+1; if the new progress equals SEQ_LEN -> OPEN.
  - non-match -> FAIL.
  - no event -> hold.
- OPEN:
  - on entry: fail_cnt=0, progress=0.
  - any press event or clear -> IDLE (relock).
- FAIL: lasts exactly one cycle. progress=0 and fail_cnt increments.
  - new fail_cnt==MAX_FAIL -> LOCKOUT, timer loaded with LOCKOUT_CYC-1.
  - otherwise -> IDLE.
  - Press events and clear during FAIL are ignored.
- LOCKOUT:
  - timer decrements each cycle; press events and clear are ignored.
  - timer==0 -> IDLE with fail_cnt=0.
  - LOCKOUT lasts exactly LOCKOUT_CYC cycles.
- clear in IDLE/ENTRY: -> IDLE with progress=0 and fail_cnt unchanged. clear has priority over a simultaneous press.
- sw_prev updates in every state, including FAIL and LOCKOUT. A switch held across the exit from LOCKOUT therefore does not generate an event.
- Reset asserted mid-entry or mid-lockout returns all registers to reset values immediately, with no clock required.

Test Plan:
Default parameters, code = {3,2,1,0} (pos0=SW0, pos1=SW1, pos2=SW2, pos3=SW3); each press is held 2 cycles and released 2 cycles.
1. Reset, then press sw=0001, 0010, 0100, 1000 -> progress goes 1,2,3; after the 4th press state=2, unlocked=1, fail_cnt=0. Next press sw=0001 -> state=0, unlocked=0.
2. Press 0001, 0010, then 1000 -> state=3 for exactly one cycle, then state=0, progress=0, fail_cnt=1.
3. Three wrong presses (sw=0100 each) -> fail_cnt 1,2,3; then state=4, alarm=1 for 16 cycles. Presses of 0001 and clear=1 during lockout have no effect. Then state=0, fail_cnt=0, alarm=0.
4. From IDLE press sw=0011 -> FAIL, fail_cnt=1. Separately, hold 0001 for 5 cycles -> a single event, progress=1 (not FAIL).
5. After 0001, 0010 (progress=2), assert clear with a simultaneous 0100 press -> state=0, progress=0, fail_cnt unchanged.
6. Drive reset=0 between clock edges at progress=3, and again mid-lockout -> state=0, progress=0, fail_cnt=0, alarm=0 immediately, before the next clk edge.
